// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the ALU command parser.
// ALU_CMD_CSUM_EN adds the checksum state to the encoding.
package alu_pkg;

    localparam logic [2:0] HDR_MARK = 3'b101;

    localparam logic [4:0] OP_SUM = 5'h10;
    localparam logic [4:0] OP_SUB = 5'h08;
    localparam logic [4:0] OP_MUL = 5'h04;
    localparam logic [4:0] OP_DIV = 5'h02;
    localparam logic [4:0] OP_RMD = 5'h01;
    localparam logic [4:0] OP_AND = 5'h11;
    localparam logic [4:0] OP_OR  = 5'h12;
    localparam logic [4:0] OP_XOR = 5'h14;

    localparam logic [3:0] DT_I = 4'h8;
    localparam logic [3:0] DT_F = 4'h4;
    localparam logic [3:0] DT_U = 4'h2;
    localparam logic [3:0] DT_S = 4'h1;
    localparam logic [3:0] DT_ALL = DT_I | DT_F | DT_U | DT_S;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DTY   = 3'd1,
        ST_S1    = 3'd2,
        ST_S2    = 3'd3,
`ifdef ALU_CMD_CSUM_EN
        ST_CSUM  = 3'd4,
`endif
        ST_ISSUE = 3'd5,
        ST_WAIT  = 3'd6,
        ST_SEND  = 3'd7
    } state_t;

    function automatic logic op_valid(input logic [4:0] op);
        logic ok;
        case (op)
            OP_SUM, OP_SUB, OP_MUL, OP_DIV,
            OP_RMD, OP_AND, OP_OR, OP_XOR: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic dtype_valid(input logic [7:0] b);
        return (b[7:4] == 4'h0) && ((b[3:0] & DT_ALL) != 4'h0);
    endfunction

endpackage

// File: rtl/alu_cmd_parser.sv
// Byte-stream command parser: frames in, one ALU issue, result byte out.
// Define ALU_CMD_CSUM_EN to require a trailing XOR checksum byte.
module alu_cmd_parser
    import alu_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [7:0] ERR_CODE       = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       parser_done,
    output logic [7:0] src1,
    output logic [7:0] src2,
    output logic [3:0] dtype,
    output logic [4:0] operator,
    input  logic       alu_done,
    input  logic [7:0] calc_res,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       err_pulse
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t state_q, state_d;

    logic [4:0]    hop_q, hop_d;
    logic [3:0]    hdt_q, hdt_d;
    logic [7:0]    hs1_q, hs1_d;
`ifdef ALU_CMD_CSUM_EN
    logic [7:0]    hs2_q, hs2_d;
    logic [7:0]    sum_q, sum_d;
`endif
    logic [4:0]    op_q, op_d;
    logic [3:0]    dt_q, dt_d;
    logic [7:0]    s1_q, s1_d;
    logic [7:0]    s2_q, s2_d;
    logic [7:0]    txd_q, txd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          rx_st;
    logic          rx_fire;

    always_comb begin
        rx_st = 1'b0;
        case (state_q)
            ST_HDR, ST_DTY, ST_S1, ST_S2: rx_st = 1'b1;
`ifdef ALU_CMD_CSUM_EN
            ST_CSUM: rx_st = 1'b1;
`endif
            default: rx_st = 1'b0;
        endcase
    end

    assign rx_ready    = rx_st & ~rst;
    assign rx_fire     = rx_valid & rx_ready;
    assign parser_done = (state_q == ST_ISSUE);
    assign tx_valid    = (state_q == ST_SEND);
    assign tx_data     = txd_q;
    assign err_pulse   = err_q;
    assign operator    = op_q;
    assign dtype       = dt_q;
    assign src1        = s1_q;
    assign src2        = s2_q;

    // Frame bytes land in staging registers; the visible operand
    // registers only change on the transfer into ISSUE.
    always_comb begin
        state_d = state_q;
        hop_d   = hop_q;
        hdt_d   = hdt_q;
        hs1_d   = hs1_q;
`ifdef ALU_CMD_CSUM_EN
        hs2_d   = hs2_q;
        sum_d   = sum_q;
`endif
        op_d    = op_q;
        dt_d    = dt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        txd_d   = txd_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_HDR: begin
                if (rx_fire) begin
                    if (rx_data[7:5] == HDR_MARK &&
                        op_valid(rx_data[4:0])) begin
                        hop_d   = rx_data[4:0];
`ifdef ALU_CMD_CSUM_EN
                        sum_d   = rx_data;
`endif
                        state_d = ST_DTY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DTY: begin
                if (rx_fire) begin
                    if (dtype_valid(rx_data)) begin
                        hdt_d   = rx_data[3:0];
`ifdef ALU_CMD_CSUM_EN
                        sum_d   = sum_q ^ rx_data;
`endif
                        state_d = ST_S1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HDR;
                    end
                end
            end
            ST_S1: begin
                if (rx_fire) begin
                    hs1_d   = rx_data;
`ifdef ALU_CMD_CSUM_EN
                    sum_d   = sum_q ^ rx_data;
`endif
                    state_d = ST_S2;
                end
            end
            ST_S2: begin
                if (rx_fire) begin
`ifdef ALU_CMD_CSUM_EN
                    hs2_d   = rx_data;
                    sum_d   = sum_q ^ rx_data;
                    state_d = ST_CSUM;
`else
                    op_d    = hop_q;
                    dt_d    = hdt_q;
                    s1_d    = hs1_q;
                    s2_d    = rx_data;
                    state_d = ST_ISSUE;
`endif
                end
            end
`ifdef ALU_CMD_CSUM_EN
            ST_CSUM: begin
                if (rx_fire) begin
                    if (rx_data == sum_q) begin
                        op_d    = hop_q;
                        dt_d    = hdt_q;
                        s1_d    = hs1_q;
                        s2_d    = hs2_q;
                        state_d = ST_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HDR;
                    end
                end
            end
`endif
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result on the last allowed cycle still wins.
                if (alu_done) begin
                    txd_d   = calc_res;
                    state_d = ST_SEND;
                end else if (cnt_q == CNT_LAST) begin
                    txd_d   = ERR_CODE;
                    err_d   = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HDR;
            hop_q   <= '0;
            hdt_q   <= '0;
            hs1_q   <= '0;
`ifdef ALU_CMD_CSUM_EN
            hs2_q   <= '0;
            sum_q   <= '0;
`endif
            op_q    <= '0;
            dt_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            txd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hop_q   <= hop_d;
            hdt_q   <= hdt_d;
            hs1_q   <= hs1_d;
`ifdef ALU_CMD_CSUM_EN
            hs2_q   <= hs2_d;
            sum_q   <= sum_d;
`endif
            op_q    <= op_d;
            dt_q    <= dt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Bench for alu_cmd_parser: vector table, directed corners, random frames.
// Honours ALU_CMD_CSUM_EN by appending the XOR checksum byte.
module tb_alu_cmd_parser;

    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready;
    logic       parser_done;
    logic [7:0] src1, src2;
    logic [3:0] dtype;
    logic [4:0] operator;
    logic       alu_done = 1'b0;
    logic [7:0] calc_res = 8'h00;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic       err_pulse;

    alu_cmd_parser #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_CODE(8'hEE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .parser_done(parser_done),
        .src1(src1),
        .src2(src2),
        .dtype(dtype),
        .operator(operator),
        .alu_done(alu_done),
        .calc_res(calc_res),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [4:0] ops_l [8] = '{5'h10, 5'h08, 5'h04, 5'h02,
                              5'h01, 5'h11, 5'h12, 5'h14};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [4:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            5'h10: return a + b;
            5'h08: return a - b;
            5'h04: return p[7:0];
            5'h02: return (b == 8'h00) ? 8'hFF : a / b;
            5'h01: return (b == 8'h00) ? 8'hFF : a % b;
            5'h11: return a & b;
            5'h12: return a | b;
            5'h14: return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit op_known(input logic [4:0] op);
        foreach (ops_l[i]) if (ops_l[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // ALU model and output monitor, sampled mid-cycle after the negedge.
    int         alu_delay = 1;
    bit         noise_en = 1'b1;
    int         tr_mode = 0;
    bit         pend = 1'b0;
    int         pend_cnt = 0;
    int         issue_cnt = 0, err_cnt = 0, tx_cnt = 0, txv_cycles = 0;
    logic [4:0] m_op;
    logic [3:0] m_dt;
    logic [7:0] m_s1, m_s2, m_tx;
    int         issue_cyc = 0, m_waits = 0, send_len = 0, cur_len = 0;
    bit         prev_txv = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_txd = 8'h00;

    always begin
        @(negedge clk);
        #1;
        if (tr_mode == 1) tx_ready = 1'($urandom_range(0, 1));
        else tx_ready = (tr_mode == 0);
        alu_done = 1'b0;
        calc_res = 8'($urandom);
        if (rst) begin
            pend = 1'b0;
            prev_txv = 1'b0;
            prev_stall = 1'b0;
            cur_len = 0;
        end else begin
            if (tx_valid) pend = 1'b0;
            if (noise_en && !pend && $urandom_range(0, 3) == 0)
                alu_done = 1'b1;
            if (pend && pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    alu_done = 1'b1;
                    calc_res = alu_ref(m_op, m_s1, m_s2);
                    pend = 1'b0;
                end
            end
            if (parser_done) begin
                issue_cnt++;
                m_op = operator;
                m_dt = dtype;
                m_s1 = src1;
                m_s2 = src2;
                issue_cyc = cyc;
                pend = 1'b1;
                pend_cnt = alu_delay;
                if (noise_en) alu_done = 1'b1;
            end
            if (err_pulse) err_cnt++;
            if (tx_valid) begin
                txv_cycles++;
                if (!prev_txv) begin
                    m_waits = cyc - issue_cyc - 1;
                    cur_len = 0;
                end
                cur_len++;
                if (tx_ready) begin
                    tx_cnt++;
                    m_tx = tx_data;
                    send_len = cur_len;
                end
            end
            if (prev_stall)
                check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_txd});
            prev_stall = tx_valid && !tx_ready;
            prev_txd = tx_data;
            prev_txv = tx_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("rx_ready_wait", 0, 1);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
`ifdef ALU_CMD_CSUM_EN
        send_byte(b0 ^ b1 ^ b2 ^ b3);
`endif
    endtask

    task automatic wait_tx(input string name, input int t0);
        int n;
        n = 0;
        while (tx_cnt == t0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check({name, ":tx_timeout"}, 0, 1);
    endtask

    task automatic run_frame(input string name,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input int delay, input logic [7:0] exp_tx,
                             input bit chk_len);
        bit hdr_ok, dty_ok, tmo;
        int i0, e0, t0;
        hdr_ok = (b0[7:5] == 3'b101) && op_known(b0[4:0]);
        dty_ok = (b1[7:4] == 4'h0) && (b1[3:0] != 4'h0);
        tmo = (delay == 0) || (delay > TMO);
        i0 = issue_cnt;
        e0 = err_cnt;
        t0 = tx_cnt;
        alu_delay = delay;
        send_byte(b0);
        if (hdr_ok) begin
            send_byte(b1);
            if (dty_ok) begin
                send_byte(b2);
                send_byte(b3);
`ifdef ALU_CMD_CSUM_EN
                send_byte(b0 ^ b1 ^ b2 ^ b3);
`endif
            end
        end
        rx_valid = 1'b0;
        if (hdr_ok && dty_ok) begin
            wait_tx(name, t0);
            check({name, ":issues"}, issue_cnt - i0, 1);
            check({name, ":op"}, m_op, b0[4:0]);
            check({name, ":dtype"}, m_dt, b1[3:0]);
            check({name, ":src"}, {m_s1, m_s2}, {b2, b3});
            check({name, ":tx"}, m_tx, exp_tx);
            check({name, ":waits"}, m_waits, tmo ? TMO : delay);
            check({name, ":err"}, err_cnt - e0, tmo ? 1 : 0);
            if (chk_len) check({name, ":send_len"}, send_len, 1);
        end else begin
            repeat (3) @(negedge clk);
            check({name, ":issues"}, issue_cnt - i0, 0);
            check({name, ":err"}, err_cnt - e0, 1);
            check({name, ":tx"}, tx_cnt - t0, 0);
        end
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        int         delay;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t vt [15];

    initial begin
        int i0, e0, t0, v0, n, stab_bad;
        vt[0]  = '{8'hB0, 8'h09, 8'h2A, 8'h11, 3,  8'h3B};
        vt[1]  = '{8'hB1, 8'h0A, 8'hF0, 8'h3C, 1,  8'h30};
        vt[2]  = '{8'h10, 8'h00, 8'h00, 8'h00, 1,  8'h00};
        vt[3]  = '{8'hB0, 8'h09, 8'h2A, 8'h11, 2,  8'h3B};
        vt[4]  = '{8'hB3, 8'h09, 8'h00, 8'h00, 1,  8'h00};
        vt[5]  = '{8'hB0, 8'h19, 8'h00, 8'h00, 1,  8'h00};
        vt[6]  = '{8'hB0, 8'h00, 8'h00, 8'h00, 1,  8'h00};
        vt[7]  = '{8'hB4, 8'h08, 8'h5A, 8'h0F, 2,  8'h55};
        vt[8]  = '{8'hB2, 8'h01, 8'h40, 8'h05, 5,  8'h45};
        vt[9]  = '{8'hA8, 8'h02, 8'h50, 8'h20, 64, 8'h30};
        vt[10] = '{8'hA4, 8'h04, 8'h07, 8'h06, 1,  8'h2A};
        vt[11] = '{8'hA2, 8'h02, 8'h64, 8'h07, 4,  8'h0E};
        vt[12] = '{8'hA1, 8'h02, 8'h64, 8'h07, 1,  8'h02};
        vt[13] = '{8'hB0, 8'h09, 8'h2A, 8'h11, 0,  8'hEE};
        vt[14] = '{8'hB0, 8'h09, 8'h2A, 8'h11, 65, 8'hEE};

        repeat (3) @(negedge clk);
        check("rst:rx_ready", rx_ready, 0);
        check("rst:outs",
              {parser_done, tx_valid, err_pulse, operator, dtype,
               src1, src2, tx_data},
              0);
        rst = 1'b0;
        #1 check("rst:rx_ready_after", rx_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 15; i++)
            run_frame($sformatf("v%0d", i), vt[i].b0, vt[i].b1,
                      vt[i].b2, vt[i].b3, vt[i].delay, vt[i].exp_tx, 1'b1);

        // Result held under backpressure; a pending rx byte is ignored.
        i0 = issue_cnt;
        e0 = err_cnt;
        t0 = tx_cnt;
        tr_mode = 2;
        alu_delay = 2;
        send_frame(8'hB0, 8'h09, 8'h2A, 8'h11);
        rx_data = 8'h10;
        n = 0;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        stab_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!(tx_valid && tx_data == 8'h3B && !rx_ready))
                stab_bad++;
        end
        check("bp:stable", stab_bad, 0);
        rx_valid = 1'b0;
        tr_mode = 0;
        wait_tx("bp", t0);
        check("bp:tx", m_tx, 8'h3B);
        check("bp:issues", issue_cnt - i0, 1);
        check("bp:err", err_cnt - e0, 0);

        // Reset mid-frame.
        send_byte(8'hB1);
        send_byte(8'h09);
        rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid:rx_ready", rx_ready, 0);
        check("rst_mid:outs",
              {parser_done, tx_valid, err_pulse, operator, dtype,
               src1, src2, tx_data},
              0);
        rst = 1'b0;
        @(negedge clk);
        run_frame("after_rst", 8'hB0, 8'h09, 8'h2A, 8'h11, 2, 8'h3B, 1'b1);

        // Reset mid-WAIT drops the pending result.
        t0 = tx_cnt;
        v0 = txv_cycles;
        alu_delay = 0;
        send_frame(8'hB0, 8'h09, 8'h2A, 8'h11);
        rx_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("rst_wait:tx", tx_cnt - t0, 0);
        check("rst_wait:txv", txv_cycles - v0, 0);

`ifdef ALU_CMD_CSUM_EN
        i0 = issue_cnt;
        e0 = err_cnt;
        send_byte(8'hB0);
        send_byte(8'h09);
        send_byte(8'h2A);
        send_byte(8'h11);
        send_byte(8'h00);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("csum_bad:issues", issue_cnt - i0, 0);
        check("csum_bad:err", err_cnt - e0, 1);
        run_frame("csum_ok", 8'hB0, 8'h09, 8'h2A, 8'h11, 3, 8'h3B, 1'b1);
`endif

        tr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int k, r, d;
            logic [4:0] op;
            logic [7:0] b0, b1, b2, b3, ex;
            k = $urandom_range(0, 9);
            r = $urandom_range(0, 9);
            op = ops_l[$urandom_range(0, 7)];
            b0 = {3'b101, op};
            b1 = {4'h0, 4'($urandom_range(1, 15))};
            b2 = 8'($urandom);
            b3 = 8'($urandom);
            if (r == 0) d = 0;
            else if (r == 1) d = $urandom_range(64, 68);
            else d = $urandom_range(1, 12);
            if (k == 0) begin
                if ($urandom_range(0, 1) != 0) b0 = {3'b101, 5'h00};
                else b0 = {3'($urandom_range(0, 4)), 5'($urandom)};
            end else if (k == 1) begin
                if ($urandom_range(0, 1) != 0) b1 = 8'h00;
                else b1 = {4'($urandom_range(1, 15)), 4'($urandom)};
            end
            ex = (d == 0 || d > TMO) ? 8'hEE : alu_ref(op, b2, b3);
            run_frame($sformatf("r%0d", i), b0, b1, b2, b3, d, ex, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_parser.md
ALU_CMD_PARSER -- requirements
Module: alu_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the maximum number of WAIT cycles allowed for alu_done.
REQ-002 Parameter ERR_CODE, default 8'hEE, is the result byte sent on timeout.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_valid  input  1  command byte valid.
REQ-006 rx_data  input  8  command byte.
REQ-007 rx_ready  output  1  parser accepts a byte; transfer on rx_valid&&rx_ready.
REQ-008 parser_done  output  1  one-cycle issue strobe to the ALU.
REQ-009 src1, src2  output  8  operands, held stable from issue until the next issue.
REQ-010 dtype  output  4  type flags (I=8, F=4, U=2, S=1).
REQ-011 operator  output  5  opcode (SUM 10, SUB 08, MUL 04, DIV 02, RMD 01, AND 11, OR 12, XOR 14; hex).
REQ-012 alu_done, calc_res  input  1/8  ALU completion and result; calc_res is valid while alu_done=1.
REQ-013 tx_valid, tx_data  output  1/8  result byte; held until tx_ready.
REQ-014 tx_ready  input  1  downstream accepts the result byte.
REQ-015 err_pulse  output  1  one-cycle error flag.

Function
REQ-016 The frame SHALL be, in order: header {3'b101, operator}, dtype byte {4'h0, dtype}, src1, src2 (plus a checksum byte when REQ-030 applies).
REQ-017 The FSM SHALL use states HDR, DTY, S1, S2, [CSUM], ISSUE, WAIT, SEND; rx_ready=1 only in HDR/DTY/S1/S2/CSUM.
REQ-018 A header with bits[7:5]!=3'b101 or an operator outside REQ-011 SHALL be discarded, pulse err_pulse, and keep the FSM in HDR.
REQ-019 A dtype byte with a nonzero upper nibble or with dtype==0 SHALL pulse err_pulse and return the FSM to HDR.
REQ-020 The cycle after the last frame byte is accepted, ISSUE SHALL drive parser_done=1 for exactly one cycle, with operator/dtype/src1/src2 already registered.
REQ-021 WAIT SHALL start on the cycle after ISSUE; the first cycle with alu_done=1 SHALL capture calc_res into tx_data and enter SEND.
REQ-022 alu_done during ISSUE or outside WAIT SHALL be ignored.
REQ-023 A WAIT counter SHALL count cycles; when the count reaches TIMEOUT_CYCLES without alu_done, the block SHALL load tx_data=ERR_CODE, pulse err_pulse, and enter SEND.
REQ-024 In SEND, tx_valid=1 and tx_data SHALL be stable until tx_valid&&tx_ready, after which the FSM enters HDR on the next cycle.
REQ-025 If tx_ready=1 in the first SEND cycle, SEND SHALL last exactly one cycle; back-to-back frames impose no extra idle cycles.
REQ-026 rx_valid while rx_ready=0 SHALL have no effect; upstream holds the byte.

Reset
REQ-027 When rst=1 at a clock edge, the FSM SHALL go to HDR, and parser_done, tx_valid, err_pulse, src1, src2, dtype, operator, tx_data and the counter SHALL all be 0.
REQ-028 rx_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-029 Reset mid-frame or mid-WAIT SHALL discard the partial frame or pending result without emitting any byte.

Configuration
REQ-030 With ALU_CMD_CSUM_EN defined, a fifth byte SHALL be required equal to the XOR of the four frame bytes; on mismatch there is no issue, err_pulse fires, and the FSM returns to HDR.
REQ-031 Without ALU_CMD_CSUM_EN, the CSUM state SHALL NOT exist and the frame SHALL be four bytes.

Structure
REQ-032 The opcode constants, dtype flags, header marker 3'b101 and FSM state encoding SHALL live in shared package alu_pkg.
REQ-033 No sub-module is required; the timeout counter is inline, and the ALU is instantiated beside the parser, not inside it.

Verification
REQ-034 Frame B0,09,2A,11 with an ALU model returning 3B -> one parser_done with operator=10, dtype=9, src1=2A, src2=11; then tx_data=3B.
REQ-035 Frame B1,0A,F0,3C (AND; alu_done on the cycle after issue) -> tx_data=30 with WAIT lasting one cycle.
REQ-036 Header 10 followed by a valid SUM frame -> err_pulse once, no issue for the bad byte, correct result for the second frame.
REQ-037 alu_done held at 0 -> exactly 64 WAIT cycles, then tx_data=EE and err_pulse=1.
REQ-038 tx_ready=0 for 10 cycles in SEND -> tx_valid and tx_data stable and rx_ready=0; the byte completes when tx_ready rises.
REQ-039 With ALU_CMD_CSUM_EN: B0,09,2A,11,00 (correct checksum 82) -> no parser_done and err_pulse; B0,09,2A,11,82 -> normal issue.
